// File: rtl/score_bcd_counter.sv
// Three-digit BCD score counter with frame-synchronised display and sticky overflow.
// Optional macro SCORE_SATURATE_EN: inc at 999 holds the count instead of wrapping to 000.
module score_bcd_counter #(
   parameter int FRAME_SYNC = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       dec,
   input  logic       clr,
   input  logic       frame_tick,
   output logic [3:0] dig0,
   output logic [3:0] dig1,
   output logic [3:0] dig2,
   output logic       ovf,
   output logic       upd
);

   localparam logic [11:0] BCD_ZERO = 12'h000;
   localparam logic [11:0] BCD_MAX  = 12'h999;

   logic [11:0] live_q, live_d;
   logic [11:0] disp_q, disp_d;
   logic        ovf_q, ovf_d;
   logic        upd_q, upd_d;

   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [11:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (c) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
               c = 1'b1;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               c = 1'b0;
            end
         end else begin
            r[i*4 +: 4] = r[i*4 +: 4];
         end
      end
      return r;
   endfunction

   function automatic logic [11:0] bcd_dec(input logic [11:0] v);
      logic [11:0] r;
      logic        b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (b) begin
            if (r[i*4 +: 4] == 4'd0) begin
               r[i*4 +: 4] = 4'd9;
               b = 1'b1;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
               b = 1'b0;
            end
         end else begin
            r[i*4 +: 4] = r[i*4 +: 4];
         end
      end
      return r;
   endfunction

   // Live count and overflow next-state, clr has highest priority
   always_comb begin
      live_d = live_q;
      ovf_d  = ovf_q;
      if (clr) begin
         live_d = BCD_ZERO;
         ovf_d  = 1'b0;
      end else if (inc && dec) begin
         live_d = live_q;
      end else if (inc) begin
         if (live_q == BCD_MAX) begin
`ifdef SCORE_SATURATE_EN
            live_d = BCD_MAX;
`else
            live_d = BCD_ZERO;
`endif
            ovf_d  = 1'b1;
         end else begin
            live_d = bcd_inc(live_q);
         end
      end else if (dec) begin
         if (live_q == BCD_ZERO) begin
            live_d = BCD_ZERO;
         end else begin
            live_d = bcd_dec(live_q);
         end
      end else begin
         live_d = live_q;
      end
   end

   // Display load point: the pre-update live count, on frame_tick or every cycle
   always_comb begin
      disp_d = disp_q;
      upd_d  = 1'b0;
      if (FRAME_SYNC != 0) begin
         if (frame_tick) begin
            disp_d = live_q;
            upd_d  = (live_q != disp_q);
         end else begin
            disp_d = disp_q;
            upd_d  = 1'b0;
         end
      end else begin
         disp_d = live_q;
         upd_d  = (live_q != disp_q);
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q <= BCD_ZERO;
         disp_q <= BCD_ZERO;
         ovf_q  <= 1'b0;
         upd_q  <= 1'b0;
      end else begin
         live_q <= live_d;
         disp_q <= disp_d;
         ovf_q  <= ovf_d;
         upd_q  <= upd_d;
      end
   end

   assign dig0 = disp_q[3:0];
   assign dig1 = disp_q[7:4];
   assign dig2 = disp_q[11:8];
   assign ovf  = ovf_q;
   assign upd  = upd_q;

endmodule

// File: tb/tb_score_bcd_counter.sv
// Bench for score_bcd_counter: frame-synced and free-running instances against an integer score model.
module tb_score_bcd_counter;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic inc = 1'b0;
   logic dec = 1'b0;
   logic clr = 1'b0;
   logic frame_tick = 1'b0;

   logic [3:0] s_dig0, s_dig1, s_dig2;
   logic       s_ovf, s_upd;
   logic [3:0] f_dig0, f_dig1, f_dig2;
   logic       f_ovf, f_upd;

   int checks = 0;
   int errors = 0;

   // reference model: plain integer score and displayed values
   int m_score = 0;
   int m_ovf = 0;
   int m_disp_s = 0;
   int m_disp_f = 0;
   int m_upd_s = 0;
   int m_upd_f = 0;

   always #5 clk = ~clk;

   score_bcd_counter #(.FRAME_SYNC(1)) dut_sync (
      .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .clr(clr), .frame_tick(frame_tick),
      .dig0(s_dig0), .dig1(s_dig1), .dig2(s_dig2), .ovf(s_ovf), .upd(s_upd)
   );

   score_bcd_counter #(.FRAME_SYNC(0)) dut_free (
      .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .clr(clr), .frame_tick(frame_tick),
      .dig0(f_dig0), .dig1(f_dig1), .dig2(f_dig2), .ovf(f_ovf), .upd(f_upd)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, " sync dig0"}, {28'd0, s_dig0}, m_disp_s % 10);
      chk({tag, " sync dig1"}, {28'd0, s_dig1}, (m_disp_s / 10) % 10);
      chk({tag, " sync dig2"}, {28'd0, s_dig2}, m_disp_s / 100);
      chk({tag, " sync upd"},  {31'd0, s_upd},  m_upd_s);
      chk({tag, " sync ovf"},  {31'd0, s_ovf},  m_ovf);
      chk({tag, " free dig0"}, {28'd0, f_dig0}, m_disp_f % 10);
      chk({tag, " free dig1"}, {28'd0, f_dig1}, (m_disp_f / 10) % 10);
      chk({tag, " free dig2"}, {28'd0, f_dig2}, m_disp_f / 100);
      chk({tag, " free upd"},  {31'd0, f_upd},  m_upd_f);
      chk({tag, " free ovf"},  {31'd0, f_ovf},  m_ovf);
   endtask

   task automatic model_reset();
      m_score = 0;
      m_ovf = 0;
      m_disp_s = 0;
      m_disp_f = 0;
      m_upd_s = 0;
      m_upd_f = 0;
   endtask

   // apply one cycle of inputs, advance the model, then check 1 time unit after the edge
   task automatic step(input string tag, input logic i_inc, input logic i_dec,
                       input logic i_clr, input logic i_tick);
      int old_score;
      inc = i_inc;
      dec = i_dec;
      clr = i_clr;
      frame_tick = i_tick;
      @(posedge clk);
      old_score = m_score;
      if (i_clr) begin
         m_score = 0;
         m_ovf = 0;
      end else if (i_inc && !i_dec) begin
         if (old_score == 999) begin
`ifdef SCORE_SATURATE_EN
            m_score = 999;
`else
            m_score = 0;
`endif
            m_ovf = 1;
         end else begin
            m_score = old_score + 1;
         end
      end else if (i_dec && !i_inc) begin
         m_score = (old_score > 0) ? old_score - 1 : 0;
      end
      if (i_tick) begin
         m_upd_s = (old_score != m_disp_s) ? 1 : 0;
         m_disp_s = old_score;
      end else begin
         m_upd_s = 0;
      end
      m_upd_f = (old_score != m_disp_f) ? 1 : 0;
      m_disp_f = old_score;
      #1;
      check_all(tag);
   endtask

   initial begin
      // asynchronous reset at start
      #1 rst_n = 1'b0;
      #1;
      check_all("reset");
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_all("post-reset idle");

      // twelve incs then a frame tick shows 012 with one upd pulse
      for (int i = 0; i < 12; i++) step("inc12", 1'b1, 1'b0, 1'b0, 1'b0);
      step("tick12", 1'b0, 1'b0, 1'b0, 1'b1);
      chk("req030 dig2", {28'd0, s_dig2}, 32'd0);
      chk("req030 dig1", {28'd0, s_dig1}, 32'd1);
      chk("req030 dig0", {28'd0, s_dig0}, 32'd2);
      chk("req030 upd", {31'd0, s_upd}, 32'd1);
      step("after tick12", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("req030 upd once", {31'd0, s_upd}, 32'd0);

      // inc coinciding with frame_tick shows pre-update 099, then 100
      step("clr", 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 99; i++) step("to99", 1'b1, 1'b0, 1'b0, 1'b0);
      step("inc+tick", 1'b1, 1'b0, 1'b0, 1'b1);
      chk("req031 disp 099", {20'd0, s_dig2, s_dig1, s_dig0}, 32'h099);
      step("idle", 1'b0, 1'b0, 1'b0, 1'b0);
      step("tick100", 1'b0, 1'b0, 1'b0, 1'b1);
      chk("req031 disp 100", {20'd0, s_dig2, s_dig1, s_dig0}, 32'h100);
      chk("req031 upd", {31'd0, s_upd}, 32'd1);

      // overflow at 999, inc&dec cancel there, then clr
      for (int i = 0; i < 899; i++) step("to999", 1'b1, 1'b0, 1'b0, 1'b0);
      step("inc&dec at 999", 1'b1, 1'b1, 1'b0, 1'b0);
      step("ovf inc", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("req032 ovf", {31'd0, s_ovf}, 32'd1);
      step("ovf hold", 1'b0, 1'b1, 1'b0, 1'b0);
      step("clr+inc", 1'b1, 1'b0, 1'b1, 1'b0);
      chk("req032 ovf cleared", {31'd0, s_ovf}, 32'd0);
      step("settle", 1'b0, 1'b0, 1'b0, 1'b1);

      // floor at 000, cancel at 050, clr beats inc
      step("dec floor", 1'b0, 1'b1, 1'b0, 1'b0);
      step("dec floor2", 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 50; i++) step("to50", 1'b1, 1'b0, 1'b0, 1'b0);
      step("inc&dec 50", 1'b1, 1'b1, 1'b0, 1'b0);
      step("see 50", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("req033 hold 050", {20'd0, f_dig2, f_dig1, f_dig0}, 32'h050);
      step("clr&inc", 1'b1, 1'b0, 1'b1, 1'b0);
      step("see 0", 1'b0, 1'b0, 1'b0, 1'b1);
      chk("req033 clr wins", {20'd0, f_dig2, f_dig1, f_dig0}, 32'h000);

      // free-running display: 15 back-to-back incs, upd every cycle
      for (int i = 0; i < 15; i++) step("inc15", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("req034 free upd", {31'd0, f_upd}, 32'd1);
      chk("req034 free disp 14", {20'd0, f_dig2, f_dig1, f_dig0}, 32'h014);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic r_inc, r_dec, r_clr, r_tick;
         r_inc  = ($urandom_range(0, 99) < ((i < 1500) ? 80 : 45));
         r_dec  = ($urandom_range(0, 99) < 35);
         r_clr  = ($urandom_range(0, 399) == 0);
         r_tick = ($urandom_range(0, 5) == 0);
         step("random", r_inc, r_dec, r_clr, r_tick);
      end

      // async reset mid-cycle at 437, then first tick loads 000 without upd
      step("clr", 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 437; i++) step("to437", 1'b1, 1'b0, 1'b0, 1'b0);
      step("show437", 1'b0, 1'b0, 1'b0, 1'b1);
      chk("req035 pre 437", {20'd0, s_dig2, s_dig1, s_dig0}, 32'h437);
      inc = 1'b1;
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_all("async reset");
      @(posedge clk);
      #1;
      check_all("held reset");
      #2 rst_n = 1'b1;
      inc = 1'b0;
      step("first tick", 1'b0, 1'b0, 1'b0, 1'b1);
      chk("req035 upd", {31'd0, s_upd}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
